// File: rtl/fadd_norm_shifter.sv
// Post-add normalization: left-shifts the raw mantissa sum by the
// leading-zero count, at most STEP bits per cycle, clamping at denormal.
module fadd_norm_shifter #(
    parameter int WIDTH = 25,
    parameter int EXP_W = 8,
    parameter int STEP  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_mant,
    input  logic [EXP_W-1:0]           in_exp,
    input  logic [$clog2(WIDTH):0]     in_lzc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_mant,
    output logic [EXP_W-1:0]           out_exp,
    output logic                       out_zero,
    output logic                       out_denorm
);

    localparam int LW = $clog2(WIDTH) + 1;
    localparam int CW = ((EXP_W > LW) ? EXP_W : LW) + 1;
    localparam logic [LW-1:0] STEP_L  = LW'(STEP);
    localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] work_mant;
    logic [LW-1:0]    rem;
    logic [EXP_W-1:0] pend_exp;
    logic             pend_zero;
    logic             pend_den;

    logic             accept;
    logic [WIDTH-1:0] acc_mant;
    logic [EXP_W-1:0] acc_exp;
    logic [LW-1:0]    acc_sh;
    logic             acc_zero;
    logic             acc_den;
    logic [CW-1:0]    lzc_c;
    logic [CW-1:0]    exp_c;

    logic [LW-1:0]    amt;
    logic [WIDTH-1:0] shifted;
    logic             last_shift;

    assign accept = in_valid && in_ready;
    assign lzc_c  = CW'(in_lzc);
    assign exp_c  = CW'(in_exp);

    // Decode shift amount and result class at accept; exponent never wraps.
    always_comb begin
        acc_mant = in_mant;
        acc_exp  = '0;
        acc_sh   = '0;
        acc_zero = 1'b0;
        acc_den  = 1'b0;
        if (in_lzc == WIDTH_L) begin
            acc_zero = 1'b1;
            acc_mant = '0;
        end else if (in_exp == '0) begin
            acc_den = 1'b1;
        end else if (lzc_c < exp_c) begin
            acc_sh  = in_lzc;
            acc_exp = in_exp - EXP_W'(in_lzc);
        end else begin
            acc_sh  = LW'(in_exp - 1'b1);
            acc_den = 1'b1;
        end
    end

    assign amt        = (rem > STEP_L) ? STEP_L : rem;
    assign shifted    = work_mant << amt;
    assign last_shift = (rem == amt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (acc_sh != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
    end

    // Results only reach the output registers when entering DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_mant  <= '0;
            rem        <= '0;
            pend_exp   <= '0;
            pend_zero  <= 1'b0;
            pend_den   <= 1'b0;
            out_mant   <= '0;
            out_exp    <= '0;
            out_zero   <= 1'b0;
            out_denorm <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                work_mant <= acc_mant;
                rem       <= acc_sh;
                pend_exp  <= acc_exp;
                pend_zero <= acc_zero;
                pend_den  <= acc_den;
                if (acc_sh == '0) begin
                    out_mant   <= acc_mant;
                    out_exp    <= acc_exp;
                    out_zero   <= acc_zero;
                    out_denorm <= acc_den;
                end
            end
        end else if (state == SHIFT) begin
            work_mant <= shifted;
            rem       <= rem - amt;
            if (last_shift) begin
                out_mant   <= shifted;
                out_exp    <= pend_exp;
                out_zero   <= pend_zero;
                out_denorm <= pend_den;
            end
        end
    end

endmodule
